// File: rtl/nms_pkg.sv
// -----------------------------------------------------------------------------
// nms_pkg
// Shared definitions for the 3x3 non-maximum suppression stage.
//   dir_e      : 2-bit quantised gradient direction code
//   DIR_BITS   : width of the direction field
//   MAG_LSB    : bit offset of the magnitude field inside a packed word
//   word_width : packed pixel word width for a given magnitude width
//   dir_lsb    : bit offset of the direction field inside a packed word
// A packed word is {dir[1:0], mag[MAG_WIDTH-1:0]}.
// -----------------------------------------------------------------------------
package nms_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    localparam int DIR_BITS = 2;
    localparam int MAG_LSB  = 0;

    function automatic int word_width(input int mag_width);
        return mag_width + DIR_BITS;
    endfunction

    function automatic int dir_lsb(input int mag_width);
        return mag_width;
    endfunction

endpackage

// File: rtl/nms_window_3x3.sv
// -----------------------------------------------------------------------------
// nms_window_3x3
// 3 rows x 3 columns of shift registers holding packed pixel words. One new
// column (row_0 top .. row_2 bottom) is shifted in per shift_en; column 0 is
// the oldest, column 2 the newest.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   shift_en            : shift the window by one column
//   row_0/row_1/row_2   : incoming column, packed {dir, mag}
//   mag[r][c]           : unpacked magnitudes of the nine window pixels
//   centre_dir          : direction of the centre pixel w[1][1]
// -----------------------------------------------------------------------------
module nms_window_3x3
    import nms_pkg::*;
#(
    parameter int MAG_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              shift_en,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_0,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_1,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_2,
    output logic [MAG_WIDTH-1:0]              mag [3][3],
    output dir_e                              centre_dir
);

    localparam int WW = word_width(MAG_WIDTH);

    logic [WW-1:0] win [3][3];
    logic [WW-1:0] rows [3];

    assign rows[0] = row_0;
    assign rows[1] = row_1;
    assign rows[2] = row_2;

    // NOTE: the window is only nine words of flops, so it is reset like any
    // other register; a real line memory would be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
                win[r][2] <= rows[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                mag[r][c] = win[r][c][MAG_LSB +: MAG_WIDTH];
            end
        end
    end

    assign centre_dir = dir_e'(win[1][1][dir_lsb(MAG_WIDTH) +: DIR_BITS]);

endmodule

// File: rtl/nms_suppress_3x3.sv
// -----------------------------------------------------------------------------
// nms_suppress_3x3
// Streaming 3x3 non-maximum suppression. Consumes column-aligned rows from a
// 3-row buffer, keeps the centre magnitude only if it is a local maximum along
// its gradient direction, and emits one result per interior pixel.
// Latency: 2 cycles (window register, output register).
// Optional feature: define NMS_LOW_THRESH_EN to add the low_thresh port and
// suppress any pixel whose magnitude is below it.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   enable                 : one incoming column is valid this cycle
//   sof                    : with enable, forces this column to (0,0)
//   row_0/row_1/row_2      : rows y-2, y-1, y, packed {dir, mag}
//   low_thresh             : suppression floor (NMS_LOW_THRESH_EN only)
//   out_valid              : single-cycle result strobe
//   out_mag                : kept magnitude or 0
//   out_dir                : centre direction
//   out_eol / out_eof      : last interior pixel of line / of frame
// -----------------------------------------------------------------------------
module nms_suppress_3x3
    import nms_pkg::*;
#(
    parameter int MAG_WIDTH    = 8,
    parameter int LINE_WIDTH   = 1920,
    parameter int FRAME_HEIGHT = 1080
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              sof,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_0,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_1,
    input  logic [word_width(MAG_WIDTH)-1:0]  row_2,
`ifdef NMS_LOW_THRESH_EN
    input  logic [MAG_WIDTH-1:0]              low_thresh,
`endif
    output logic                              out_valid,
    output logic [MAG_WIDTH-1:0]              out_mag,
    output logic [1:0]                        out_dir,
    output logic                              out_eol,
    output logic                              out_eof
);

    localparam int XW = $clog2(LINE_WIDTH);
    localparam int YW = $clog2(FRAME_HEIGHT);

    // ---------------- position of the incoming column ----------------
    logic [XW-1:0] x_q, col_x;
    logic [YW-1:0] y_q, col_y;
    logic          last_x, last_y, win_done;

    // sof overrides the running counters so a misaligned stream realigns here.
    assign col_x    = sof ? '0 : x_q;
    assign col_y    = sof ? '0 : y_q;
    assign last_x   = (col_x == XW'(LINE_WIDTH - 1));
    assign last_y   = (col_y == YW'(FRAME_HEIGHT - 1));
    // Columns 0/1 of a line still have stale columns from the previous line
    // in the window, so only x >= 2 completes a window.
    assign win_done = enable && (col_x >= XW'(2)) && (col_y >= YW'(2));

    // NOTE: every sequential block uses non-blocking assignments so all
    // registers see pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (enable) begin
            if (last_x) begin
                x_q <= '0;
                y_q <= last_y ? '0 : col_y + 1'b1;
            end else begin
                x_q <= col_x + 1'b1;
                y_q <= col_y;
            end
        end
    end

    // ---------------- window stage ----------------
    logic [MAG_WIDTH-1:0] mag [3][3];
    dir_e                 centre_dir;
    logic                 win_valid_q, win_eol_q, win_eof_q;

    nms_window_3x3 #(.MAG_WIDTH(MAG_WIDTH)) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (enable),
        .row_0      (row_0),
        .row_1      (row_1),
        .row_2      (row_2),
        .mag        (mag),
        .centre_dir (centre_dir)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_eol_q   <= 1'b0;
            win_eof_q   <= 1'b0;
        end else begin
            win_valid_q <= win_done;
            if (win_done) begin
                win_eol_q <= last_x;
                win_eof_q <= last_x && last_y;
            end
        end
    end

    // ---------------- direction select and compare ----------------
    logic [MAG_WIDTH-1:0] mag_a, mag_b, mag_c;
    logic                 thresh_ok, keep;

    assign mag_c = mag[1][1];

    // NOTE: defaults first so every path assigns mag_a/mag_b and no latch
    // is inferred.
    always_comb begin
        mag_a = '0;
        mag_b = '0;
        case (centre_dir)
            DIR_0:   begin mag_a = mag[1][0]; mag_b = mag[1][2]; end
            DIR_45:  begin mag_a = mag[0][2]; mag_b = mag[2][0]; end
            DIR_90:  begin mag_a = mag[0][1]; mag_b = mag[2][1]; end
            DIR_135: begin mag_a = mag[0][0]; mag_b = mag[2][2]; end
            default: begin mag_a = '0;        mag_b = '0;        end
        endcase
    end

`ifdef NMS_LOW_THRESH_EN
    assign thresh_ok = (mag_c >= low_thresh);
`else
    assign thresh_ok = 1'b1;
`endif

    // Strict against the earlier neighbour, non-strict against the later one,
    // so a flat run keeps exactly one pixel.
    assign keep = (mag_c > mag_a) && (mag_c >= mag_b) && thresh_ok;

    // ---------------- output stage ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_dir   <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= win_valid_q;
            if (win_valid_q) begin
                out_mag <= keep ? mag_c : '0;
                out_dir <= centre_dir;
                out_eol <= win_eol_q;
                out_eof <= win_eof_q;
            end
        end
    end

endmodule
